// File: rtl/npc_sequencer.sv
// Multi-cycle fetch/execute/memory/writeback sequencer for a non-pipelined core.
// Owns pc, the latched instruction word, the retire counter and the halt state.
module npc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic        is_mem,
  input  logic        is_ebreak,
  input  logic        is_jump,
  input  logic [31:0] jump_target,
  input  logic        wr_rd,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        rf_we,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halt
);

  typedef enum logic [2:0] {
    FETCH, IWAIT, EXEC, MREQ, MWAIT, WB, HALT
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t state;
  state_t state_next;
  logic   inst_load;
  logic   wr_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_next = state;
    inst_load  = 1'b0;
    case (state)
      FETCH: begin
        if (imem_gnt && imem_rvalid) begin
          inst_load  = 1'b1;
          state_next = EXEC;
        end else if (imem_gnt) begin
          state_next = IWAIT;
        end
      end
      IWAIT: begin
        if (imem_rvalid) begin
          inst_load  = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (is_ebreak)   state_next = HALT;
        else if (is_mem) state_next = MREQ;
        else             state_next = WB;
      end
      MREQ: begin
        if (dmem_gnt && dmem_rvalid) state_next = WB;
        else if (dmem_gnt)           state_next = MWAIT;
      end
      MWAIT:   if (dmem_rvalid) state_next = WB;
      WB:      state_next = FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      inst    <= NOP;
      instret <= '0;
      wr_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (inst_load) inst <= imem_rdata;
      // wr_rd is captured in EXEC so rf_we depends on registered state only.
      if (state == EXEC) wr_q <= wr_rd;
      if (state == WB) begin
        instret <= instret + 32'd1;
        pc      <= is_jump ? (jump_target & 32'hFFFF_FFFC) : pc + 32'd4;
      end
    end
  end

  // Reset parks the FSM in FETCH, so the fetch request is held off until release.
  assign imem_req = (state == FETCH) && !rst;
  assign dmem_req = (state == MREQ);
  assign retire   = (state == WB);
  assign rf_we    = (state == WB) && wr_q;
  assign halt     = (state == HALT);

endmodule

// File: doc/npc_sequencer.md
NPC_SEQUENCER -- requirements
Module: npc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning PC value loaded at reset.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port imem_req  output  1  instruction fetch request, address = pc.
REQ-005 SHALL have port imem_gnt  input  1  fetch request accepted this cycle.
REQ-006 SHALL have port imem_rvalid  input  1  imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-008 SHALL have port dmem_req  output  1  data access request for load/store.
REQ-009 SHALL have port dmem_gnt  input  1  data request accepted this cycle.
REQ-010 SHALL have port dmem_rvalid  input  1  data access complete this cycle.
REQ-011 SHALL have port is_mem  input  1  decoded instruction needs data memory.
REQ-012 SHALL have port is_ebreak  input  1  decoded instruction is ebreak.
REQ-013 SHALL have port is_jump  input  1  decoded instruction redirects PC.
REQ-014 SHALL have port jump_target  input  32  redirect address.
REQ-015 SHALL have port wr_rd  input  1  decoded instruction writes rd.
REQ-016 SHALL have port pc  output  32  address of current instruction.
REQ-017 SHALL have port inst  output  32  latched instruction, drives the decoder.
REQ-018 SHALL have port rf_we  output  1  register-file write enable.
REQ-019 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-020 SHALL have port instret  output  32  retired-instruction count.
REQ-021 SHALL have port halt  output  1  core stopped by ebreak.

Function
REQ-022 SHALL implement states FETCH, IWAIT, EXEC, MREQ, MWAIT, WB, HALT; one state per cycle minimum.
REQ-023 FETCH: imem_req=1; gnt&rvalid -> latch inst, go EXEC; gnt only -> IWAIT; else stay.
REQ-024 IWAIT: imem_req=0; rvalid -> latch imem_rdata into inst, go EXEC; else stay.
REQ-025 EXEC: decode inputs sampled; is_ebreak -> HALT (priority over is_mem); else is_mem -> MREQ; else WB.
REQ-026 MREQ: dmem_req=1; gnt&rvalid -> WB; gnt only -> MWAIT; else stay.
REQ-027 MWAIT: dmem_req=0; rvalid -> WB; else stay.
REQ-028 WB: rf_we=wr_rd; retire=1; instret+=1 (mod 2^32); pc <= is_jump ? {jump_target[31:2],2'b00} : pc+4 (mod 2^32); go FETCH.
REQ-029 HALT: halt=1, all requests 0, rf_we=0, retire=0; sticky until rst; pc/inst/instret frozen.
REQ-030 imem_req, dmem_req, rf_we, retire, halt SHALL be pure functions of state (Moore), no input-to-output combinational path.
REQ-031 inst SHALL change only on fetch completion; pc only in WB; both stable EXEC through WB.
REQ-032 imem_rvalid/dmem_rvalid outside IWAIT/FETCH resp. MREQ/MWAIT SHALL be ignored.
REQ-033 Latency: single-cycle memories, non-mem instruction = 3 cycles (FETCH,EXEC,WB); mem instruction = 4.

Reset
REQ-034 rst high SHALL immediately force state FETCH, pc=RESET_PC, inst=32'h0000_0013, instret=0, halt=0, imem_req=0 while rst held.
REQ-035 While rst high all outputs except pc/inst SHALL be 0; imem_req asserts first cycle after rst deasserts.
REQ-036 rst mid-transaction (any state incl. IWAIT/MWAIT/HALT) SHALL abandon the access; no retire, no rf_we, late rvalid after release ignored unless state is FETCH/IWAIT.

Verification
REQ-037 Reset release, gnt=rvalid=1 always, addi stream -> pc 8000_0000, 8000_0004, 8000_0008 at 3-cycle spacing, retire every 3rd cycle, instret=3 after 9 cycles.
REQ-038 imem_gnt delayed 2 cycles, rvalid 3 cycles after gnt -> imem_req held 3 cycles, inst updated only on rvalid, single retire.
REQ-039 Load (is_mem=1, wr_rd=1), dmem_gnt 1 cycle late -> dmem_req 2 cycles, rf_we=1 exactly one cycle in WB, pc+4.
REQ-040 is_jump=1, jump_target=8000_0103 -> next pc 8000_0100.
REQ-041 ebreak with is_mem=1 also set -> HALT, halt=1, no dmem_req, instret unchanged for 20 further cycles.
REQ-042 rst pulsed in MWAIT then late dmem_rvalid -> pc=8000_0000, instret=0, no rf_we, normal fetch resumes.
